// File: rtl/bbox_scan_ctrl.sv
// Triangle bounding-box raster sequencer: rounds/clamps the vertex box, then emits pixel samples row-major.
// First sample two cycles after accept, one per cycle after that; sample outputs hold while samp_ready is low.
module bbox_scan_ctrl #(
    parameter int W        = 16,
    parameter int FRAC     = 6,
    parameter int SCREEN_W = 320,
    parameter int SCREEN_H = 240
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         tri_valid,
    output logic         tri_ready,
    input  logic [W-1:0] v0x,
    input  logic [W-1:0] v1x,
    input  logic [W-1:0] v2x,
    input  logic [W-1:0] v0y,
    input  logic [W-1:0] v1y,
    input  logic [W-1:0] v2y,
    output logic         samp_valid,
    input  logic         samp_ready,
    output logic [W-1:0] samp_x,
    output logic [W-1:0] samp_y,
    output logic         samp_last,
    output logic         tri_done,
    output logic         busy
);

    localparam int          XLIM_I = (SCREEN_W - 1) * (2 ** FRAC);
    localparam int          YLIM_I = (SCREEN_H - 1) * (2 ** FRAC);
    localparam logic [W-1:0] XLIM  = XLIM_I[W-1:0];
    localparam logic [W-1:0] YLIM  = YLIM_I[W-1:0];
    localparam logic [W-1:0] STEP  = W'(1 << FRAC);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BOX  = 2'd1,
        S_SCAN = 2'd2,
        S_DONE = 2'd3
    } state_t;

    function automatic logic [W-1:0] min3(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [W-1:0] c);
        logic [W-1:0] m;
        m = (a < b) ? a : b;
        return (c < m) ? c : m;
    endfunction

    function automatic logic [W-1:0] max3(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [W-1:0] c);
        logic [W-1:0] m;
        m = (a > b) ? a : b;
        return (c > m) ? c : m;
    endfunction

    // Round to nearest pixel, half up; wraps modulo 2^W.
    function automatic logic [W-1:0] round_px(input logic [W-1:0] u);
        logic [W-1:0] r;
        r = {u[W-1:FRAC], {FRAC{1'b0}}};
        if (u[FRAC-1]) begin
            r = r + STEP;
        end
        return r;
    endfunction

    state_t       state_q;
    logic [W-1:0] vx0_q, vx1_q, vx2_q;
    logic [W-1:0] vy0_q, vy1_q, vy2_q;
    logic [W-1:0] xmin_q, xmax_q, ymax_q;
    logic [W-1:0] samp_x_q, samp_y_q;
    logic         samp_valid_q, tri_done_q, busy_q, tri_ready_q;

    logic [W-1:0] xmin_r, xmax_r, ymin_r, ymax_r;
    logic [W-1:0] xmax_c, ymax_c;
    logic         box_empty;
    logic [W-1:0] samp_x_d, samp_y_d;
    logic         samp_hs;

    always_comb begin
        xmin_r    = round_px(min3(vx0_q, vx1_q, vx2_q));
        xmax_r    = round_px(max3(vx0_q, vx1_q, vx2_q));
        ymin_r    = round_px(min3(vy0_q, vy1_q, vy2_q));
        ymax_r    = round_px(max3(vy0_q, vy1_q, vy2_q));
        xmax_c    = (xmax_r > XLIM) ? XLIM : xmax_r;
        ymax_c    = (ymax_r > YLIM) ? YLIM : ymax_r;
        // A max that wrapped past 2^W would never be reached by the scan; drop the box.
        box_empty = (xmin_r > XLIM) || (ymin_r > YLIM) || (xmax_c < xmin_r) || (ymax_c < ymin_r);
    end

    always_comb begin
        samp_x_d = samp_x_q;
        samp_y_d = samp_y_q;
        if (samp_x_q < xmax_q) begin
            samp_x_d = samp_x_q + STEP;
        end else begin
            samp_x_d = xmin_q;
            samp_y_d = samp_y_q + STEP;
        end
    end

    assign samp_hs    = samp_valid_q && samp_ready;
    assign samp_last  = samp_valid_q && (samp_x_q == xmax_q) && (samp_y_q == ymax_q);
    assign samp_valid = samp_valid_q;
    assign samp_x     = samp_x_q;
    assign samp_y     = samp_y_q;
    assign tri_done   = tri_done_q;
    assign busy       = busy_q;
    assign tri_ready  = tri_ready_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            vx0_q        <= '0;
            vx1_q        <= '0;
            vx2_q        <= '0;
            vy0_q        <= '0;
            vy1_q        <= '0;
            vy2_q        <= '0;
            xmin_q       <= '0;
            xmax_q       <= '0;
            ymax_q       <= '0;
            samp_x_q     <= '0;
            samp_y_q     <= '0;
            samp_valid_q <= 1'b0;
            tri_done_q   <= 1'b0;
            busy_q       <= 1'b0;
            tri_ready_q  <= 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    tri_done_q <= 1'b0;
                    if (tri_valid && tri_ready_q) begin
                        vx0_q       <= v0x;
                        vx1_q       <= v1x;
                        vx2_q       <= v2x;
                        vy0_q       <= v0y;
                        vy1_q       <= v1y;
                        vy2_q       <= v2y;
                        tri_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= S_BOX;
                    end
                end
                S_BOX: begin
                    xmin_q <= xmin_r;
                    xmax_q <= xmax_c;
                    ymax_q <= ymax_c;
                    if (box_empty) begin
                        tri_done_q <= 1'b1;
                        state_q    <= S_DONE;
                    end else begin
                        samp_x_q     <= xmin_r;
                        samp_y_q     <= ymin_r;
                        samp_valid_q <= 1'b1;
                        state_q      <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (samp_hs) begin
                        if (samp_last) begin
                            samp_valid_q <= 1'b0;
                            tri_done_q   <= 1'b1;
                            state_q      <= S_DONE;
                        end else begin
                            samp_x_q <= samp_x_d;
                            samp_y_q <= samp_y_d;
                        end
                    end
                end
                S_DONE: begin
                    tri_done_q  <= 1'b0;
                    busy_q      <= 1'b0;
                    tri_ready_q <= 1'b1;
                    state_q     <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bbox_scan_ctrl.sv
// Directed bench for bbox_scan_ctrl: hand-computed boxes, stall, clamp, empty and mid-scan reset.
module tb_bbox_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tri_valid;
    logic        tri_ready;
    logic [15:0] v0x, v1x, v2x, v0y, v1y, v2y;
    logic        samp_valid;
    logic        samp_ready;
    logic [15:0] samp_x, samp_y;
    logic        samp_last;
    logic        tri_done;
    logic        busy;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    bbox_scan_ctrl #(.W(16), .FRAC(6), .SCREEN_W(320), .SCREEN_H(240)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tri_valid  (tri_valid),
        .tri_ready  (tri_ready),
        .v0x        (v0x),
        .v1x        (v1x),
        .v2x        (v2x),
        .v0y        (v0y),
        .v1y        (v1y),
        .v2y        (v2y),
        .samp_valid (samp_valid),
        .samp_ready (samp_ready),
        .samp_x     (samp_x),
        .samp_y     (samp_y),
        .samp_last  (samp_last),
        .tri_done   (tri_done),
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge only.
    task automatic run_tri(input string tag,
                           input logic [15:0] ax, input logic [15:0] ay,
                           input logic [15:0] bx, input logic [15:0] by,
                           input logic [15:0] cx, input logic [15:0] cy,
                           input int xmin, input int xmax, input int ymin, input int ymax,
                           input bit empty, input int stall_k, input bit hold);
        int k;
        @(negedge clk);
        tri_valid = 1'b1;
        v0x = ax; v0y = ay; v1x = bx; v1y = by; v2x = cx; v2y = cy;
        @(negedge clk);
        if (hold) begin
            v0x = '0; v0y = '0; v1x = '0; v1y = '0; v2x = '0; v2y = '0;
        end else begin
            tri_valid = 1'b0;
        end
        check({tag, ".box_busy"}, busy, 1);
        check({tag, ".box_ready"}, tri_ready, 0);
        check({tag, ".box_valid"}, samp_valid, 0);
        if (empty) begin
            @(negedge clk);
            tri_valid = 1'b0;
            check({tag, ".empty_valid"}, samp_valid, 0);
            check({tag, ".empty_done"}, tri_done, 1);
        end else begin
            k = 0;
            for (int y = ymin; y <= ymax; y += 64) begin
                for (int x = xmin; x <= xmax; x += 64) begin
                    @(negedge clk);
                    if (k == stall_k) begin
                        samp_ready = 1'b0;
                        repeat (5) begin
                            check($sformatf("%s.stall_v%0d", tag, k), samp_valid, 1);
                            check($sformatf("%s.stall_x%0d", tag, k), samp_x, x);
                            check($sformatf("%s.stall_y%0d", tag, k), samp_y, y);
                            @(negedge clk);
                        end
                        samp_ready = 1'b1;
                    end
                    check($sformatf("%s.v%0d", tag, k), samp_valid, 1);
                    check($sformatf("%s.x%0d", tag, k), samp_x, x);
                    check($sformatf("%s.y%0d", tag, k), samp_y, y);
                    check($sformatf("%s.last%0d", tag, k), samp_last, (x == xmax && y == ymax) ? 1 : 0);
                    check($sformatf("%s.done%0d", tag, k), tri_done, 0);
                    k++;
                end
            end
            @(negedge clk);
            tri_valid = 1'b0;
            check({tag, ".end_valid"}, samp_valid, 0);
            check({tag, ".end_done"}, tri_done, 1);
            check({tag, ".end_busy"}, busy, 1);
        end
        @(negedge clk);
        check({tag, ".idle_done"}, tri_done, 0);
        check({tag, ".idle_ready"}, tri_ready, 1);
        check({tag, ".idle_busy"}, busy, 0);
        check({tag, ".idle_valid"}, samp_valid, 0);
    endtask

    initial begin
        rst_n = 1'b0; tri_valid = 1'b0; samp_ready = 1'b1;
        v0x = '0; v1x = '0; v2x = '0; v0y = '0; v1y = '0; v2y = '0;
        repeat (2) @(negedge clk);
        check("rst.ready", tri_ready, 1);
        check("rst.valid", samp_valid, 0);
        check("rst.busy", busy, 0);
        check("rst.done", tri_done, 0);
        check("rst.last", samp_last, 0);
        check("rst.x", samp_x, 0);
        check("rst.y", samp_y, 0);
        rst_n = 1'b1;

        // 3x3 box, then the same box with a 5-cycle stall on the centre sample.
        run_tri("t9", 16'h40, 16'h40, 16'hC0, 16'h40, 16'h40, 16'hC0,
                'h40, 'hC0, 'h40, 'hC0, 1'b0, -1, 1'b0);
        run_tri("t9s", 16'h40, 16'h40, 16'hC0, 16'h40, 16'h40, 16'hC0,
                'h40, 'hC0, 'h40, 'hC0, 1'b0, 4, 1'b0);
        // 0x5F rounds down to 0x40; 0x9F (2 + 31/64) rounds down to 0x80.
        run_tri("rnd_dn", 16'h60, 16'h40, 16'h5F, 16'h40, 16'h9F, 16'h40,
                'h40, 'h80, 'h40, 'h40, 1'b0, -1, 1'b0);
        // 0xA0 is exactly half a pixel past 0x80 and rounds up to 0xC0; tri_valid held while busy.
        run_tri("rnd_up", 16'h60, 16'h40, 16'h5F, 16'h40, 16'hA0, 16'h40,
                'h40, 'hC0, 'h40, 'h40, 1'b0, -1, 1'b1);
        run_tri("pix1", 16'h100, 16'h100, 16'h100, 16'h100, 16'h100, 16'h100,
                'h100, 'h100, 'h100, 'h100, 1'b0, -1, 1'b0);
        run_tri("empty", 16'h5000, 16'h40, 16'h5000, 16'h40, 16'h5000, 16'h40,
                0, 0, 0, 0, 1'b1, -1, 1'b0);
        // x max 0x6000 clamps to 0x4FC0: four samples per row, two rows.
        run_tri("clamp", 16'h4F00, 16'h40, 16'h6000, 16'h80, 16'h5000, 16'h40,
                'h4F00, 'h4FC0, 'h40, 'h80, 1'b0, -1, 1'b0);

        // Reset during the scan aborts it with no tri_done.
        @(negedge clk);
        tri_valid = 1'b1;
        v0x = 16'h40; v0y = 16'h40; v1x = 16'hC0; v1y = 16'h40; v2x = 16'h40; v2y = 16'hC0;
        @(negedge clk);
        tri_valid = 1'b0;
        @(negedge clk);
        check("abort.x0", samp_x, 'h40);
        @(negedge clk);
        check("abort.x1", samp_x, 'h80);
        @(negedge clk);
        check("abort.x2", samp_x, 'hC0);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort.valid", samp_valid, 0);
        check("abort.busy", busy, 0);
        check("abort.ready", tri_ready, 1);
        check("abort.done", tri_done, 0);
        check("abort.last", samp_last, 0);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("abort.post_done", tri_done, 0);
            check("abort.post_valid", samp_valid, 0);
        end
        run_tri("recover", 16'h100, 16'h100, 16'h100, 16'h100, 16'h100, 16'h100,
                'h100, 'h100, 'h100, 'h100, 1'b0, -1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
